// File: rtl/imem_load_ctrl_if.sv
// Byte-stream loader bundle: host stream/control side plus instruction-memory write port.
// slave = loader controller, master = host/testbench side.
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, word_count, abort, in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, core_hold, busy, done, err
  );

  modport master (
    output start, word_count, abort, in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, core_hold, busy, done, err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: assembles little-endian bytes into 32-bit words,
// writes them from address 0 upward and holds the core while loading.
module imem_load_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  imem_load_ctrl_if.slave    bus
);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  MAX_WORDS  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [IDLE_W-1:0] IDLE_LAST  = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;
  localparam logic              TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  waddr_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_buf_q;
  logic [IDLE_W-1:0] idle_ctr_q;
  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [31:0]       mem_wdata_q;
  logic              core_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              hs_d;
  logic              idle_to_d;
  logic [CNT_W-1:0]  waddr_inc_d;
  logic [31:0]       merged_d;

  assign hs_d        = bus.in_valid & in_ready_q;
  assign idle_to_d   = TIMEOUT_EN & (idle_ctr_q == IDLE_LAST);
  assign waddr_inc_d = waddr_q + CNT_W'(1);

  // Word buffer with the incoming byte placed at the current byte lane
  always_comb begin
    merged_d = word_buf_q;
    merged_d[8*byte_idx_q +: 8] = bus.in_data;
  end

  // Load sequencer with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      waddr_q     <= '0;
      byte_idx_q  <= 2'd0;
      word_buf_q  <= 32'd0;
      idle_ctr_q  <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= 32'd0;
      core_hold_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            err_q <= 1'b0;
            if (bus.word_count == '0) begin
              // Empty load completes without stalling the core
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              cnt_q       <= (bus.word_count > MAX_WORDS) ? MAX_WORDS : bus.word_count;
              waddr_q     <= '0;
              byte_idx_q  <= 2'd0;
              idle_ctr_q  <= '0;
              state_q     <= S_COLLECT;
              in_ready_q  <= 1'b1;
              core_hold_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (bus.abort) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            core_hold_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (hs_d) begin
            word_buf_q <= merged_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            idle_ctr_q <= '0;
            if (byte_idx_q == 2'd3) begin
              state_q     <= S_WRITE;
              in_ready_q  <= 1'b0;
              we_q        <= 1'b1;
              mem_waddr_q <= waddr_q[ADDR_W-1:0];
              mem_wdata_q <= merged_d;
            end
          end else if (idle_to_d) begin
            err_q       <= 1'b1;
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            core_hold_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            idle_ctr_q <= idle_ctr_q + IDLE_W'(1);
          end
        end
        S_WRITE: begin
          if (bus.abort) begin
            state_q     <= S_IDLE;
            core_hold_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (waddr_inc_d == cnt_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            waddr_q    <= waddr_inc_d;
            byte_idx_q <= 2'd0;
            state_q    <= S_COLLECT;
            in_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          core_hold_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          core_hold_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Abort must kill the write the memory would otherwise take at the end of this cycle
  assign bus.mem_we    = we_q & ~bus.abort;
  assign bus.in_ready  = in_ready_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.core_hold = core_hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: continuous/throttled loads, empty load,
// abort, idle timeout and asynchronous reset mid-load.
module tb_imem_load_ctrl;
  logic clk;
  logic reset;

  imem_load_ctrl_if #(.ADDR_W(8)) bus ();

  imem_load_ctrl #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stream [0:15];
  int          ptr;
  int          done_cnt, done_cyc, hold_cnt, hold_first, hold_last, nw, ready1;
  logic [7:0]  wa [0:7];
  logic [31:0] wd [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a load in cycle 0, then run ncyc cycles feeding the stream and recording outputs.
  task automatic run_load(input logic [8:0] wc, input int ncyc, input bit toggle,
                          input int nbytes_max, input int abort_cyc);
    bit v;
    ptr = 0; done_cnt = 0; done_cyc = -1; hold_cnt = 0; hold_first = -1; hold_last = -1;
    nw = 0; ready1 = 0;
    bus.start = 1'b1; bus.word_count = wc; bus.in_valid = 1'b0; bus.abort = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.done) begin done_cnt++; done_cyc = c; end
      if (bus.core_hold) begin
        hold_cnt++;
        if (hold_first < 0) hold_first = c;
        hold_last = c;
      end
      if (c == 1) ready1 = int'(bus.in_ready);
      if (c == abort_cyc) begin
        bus.abort = 1'b1; bus.start = 1'b1;
        #1;
      end else begin
        bus.abort = 1'b0; bus.start = 1'b0;
      end
      if (bus.mem_we && nw < 8) begin
        wa[nw] = bus.mem_waddr; wd[nw] = bus.mem_wdata; nw++;
      end
      v = (ptr < nbytes_max) && (ptr < 16) && (!toggle || (c % 2 == 1));
      bus.in_valid = v;
      bus.in_data  = (ptr < 16) ? stream[ptr] : 8'h00;
      if (v && bus.in_ready && !bus.abort) ptr++;
      tick();
    end
    bus.abort = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
    chk({tag, "_mem_we"},    {31'd0, bus.mem_we},    32'd0);
    chk({tag, "_mem_waddr"}, {24'd0, bus.mem_waddr}, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,          32'd0);
    chk({tag, "_core_hold"}, {31'd0, bus.core_hold}, 32'd0);
    chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
    chk({tag, "_done"},      {31'd0, bus.done},      32'd0);
    chk({tag, "_err"},       {31'd0, bus.err},       32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.word_count = 9'd0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    reset = 1'b1;
    stream[0] = 8'h13; stream[1] = 8'h00; stream[2] = 8'h10; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h00; stream[6] = 8'h10; stream[7] = 8'h00;
    for (int i = 8; i < 16; i++) stream[i] = 8'(8'h40 + i);
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Two words at full rate
    run_load(9'd2, 12, 1'b0, 16, -1);
    chk("a_ready1",    ready1,     32'd1);
    chk("a_done_cyc",  done_cyc,   32'd11);
    chk("a_done_cnt",  done_cnt,   32'd1);
    chk("a_hold_cnt",  hold_cnt,   32'd11);
    chk("a_hold_first", hold_first, 32'd1);
    chk("a_hold_last", hold_last,  32'd11);
    chk("a_nw",        nw,         32'd2);
    chk("a_wa0",       {24'd0, wa[0]}, 32'd0);
    chk("a_wd0",       wd[0],      32'h00100013);
    chk("a_wa1",       {24'd0, wa[1]}, 32'd1);
    chk("a_wd1",       wd[1],      32'h00100093);
    chk("a_bytes",     ptr,        32'd8);
    chk("a_busy_end",  {31'd0, bus.busy}, 32'd0);

    // Same stream, valid every other cycle
    run_load(9'd2, 20, 1'b1, 16, -1);
    chk("b_nw",       nw,        32'd2);
    chk("b_wd0",      wd[0],     32'h00100013);
    chk("b_wd1",      wd[1],     32'h00100093);
    chk("b_wa1",      {24'd0, wa[1]}, 32'd1);
    chk("b_bytes",    ptr,       32'd8);
    chk("b_done_cyc", done_cyc,  32'd17);
    chk("b_err",      {31'd0, bus.err}, 32'd0);

    // Empty load
    run_load(9'd0, 3, 1'b0, 16, -1);
    chk("c_done_cyc", done_cyc, 32'd1);
    chk("c_done_cnt", done_cnt, 32'd1);
    chk("c_nw",       nw,       32'd0);
    chk("c_hold",     hold_cnt, 32'd0);

    // Three words, abort (with a concurrent start) in the second WRITE cycle
    run_load(9'd3, 14, 1'b0, 16, 10);
    chk("d_nw",        nw,        32'd1);
    chk("d_wd0",       wd[0],     32'h00100013);
    chk("d_done_cnt",  done_cnt,  32'd0);
    chk("d_hold_last", hold_last, 32'd10);
    chk("d_busy_end",  {31'd0, bus.busy}, 32'd0);
    chk("d_err",       {31'd0, bus.err},  32'd0);

    // Idle timeout after two bytes (TIMEOUT=16)
    run_load(9'd1, 18, 1'b0, 2, -1);
    chk("e_err",       {31'd0, bus.err},  32'd1);
    chk("e_busy",      {31'd0, bus.busy}, 32'd0);
    chk("e_hold_last", hold_last, 32'd18);
    chk("e_nw",        nw,        32'd0);
    chk("e_done_cnt",  done_cnt,  32'd0);

    // Next start clears err; stall mid-word, then reset asynchronously
    run_load(9'd1, 4, 1'b0, 2, -1);
    chk("f_err_clr", {31'd0, bus.err},  32'd0);
    chk("f_busy",    {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("f_async");
    tick();
    reset = 1'b0;
    tick();

    stream[0] = 8'hAA; stream[1] = 8'hBB; stream[2] = 8'hCC; stream[3] = 8'hDD;
    run_load(9'd1, 7, 1'b0, 16, -1);
    chk("g_nw",       nw,       32'd1);
    chk("g_wa0",      {24'd0, wa[0]}, 32'd0);
    chk("g_wd0",      wd[0],    32'hDDCCBBAA);
    chk("g_done_cyc", done_cyc, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
